// File: rtl/cache_pkg.sv
// Shared geometry, address-split helpers and FSM state type for the write-through data cache.
package cache_pkg;
  localparam int WORD_SIZE  = 16;
  localparam int LINE_WORDS = 4;
  localparam int NUM_LINES  = 4;
  localparam int MEM_LAT    = 2;

  localparam int OFFSET_W = $clog2(LINE_WORDS);
  localparam int INDEX_W  = $clog2(NUM_LINES);
  localparam int TAG_W    = WORD_SIZE - INDEX_W - OFFSET_W;
  localparam int BEAT_W   = $clog2(MEM_LAT);

  typedef logic [WORD_SIZE-1:0] word_t;
  typedef logic [TAG_W-1:0]     tag_t;
  typedef logic [INDEX_W-1:0]   index_t;
  typedef logic [OFFSET_W-1:0]  offset_t;
  typedef logic [BEAT_W-1:0]    beat_t;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;

  function automatic tag_t addr_tag(input word_t a);
    return a[WORD_SIZE-1 -: TAG_W];
  endfunction

  function automatic index_t addr_index(input word_t a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic offset_t addr_offset(input word_t a);
    return a[OFFSET_W-1:0];
  endfunction
endpackage

// File: rtl/dcache_wt_if.sv
// CPU data port, memory port 2 and performance counters of the cache in one bundle.
interface dcache_wt_if;
  import cache_pkg::*;

  logic  cpu_req;
  logic  cpu_we;
  word_t cpu_addr;
  word_t cpu_wdata;
  word_t cpu_rdata;
  logic  cpu_ready;
  logic  mem_read;
  logic  mem_write;
  word_t mem_addr;
  word_t mem_wdata;
  word_t mem_rdata;
  word_t hit_count;
  word_t access_count;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_rdata, cpu_ready, mem_read, mem_write, mem_addr, mem_wdata,
           hit_count, access_count
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_rdata, cpu_ready, mem_read, mem_write, mem_addr, mem_wdata,
           hit_count, access_count
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Cache sequencer: IDLE/FILL/WRITE state, beat and word counters, registered memory strobes.
module dcache_ctrl
  import cache_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    req_i,
  input  logic    we_i,
  input  logic    hit_i,
  output state_e  state_o,
  output offset_t word_o,
  output logic    mem_read_o,
  output logic    mem_write_o,
  output logic    miss_flag_o,
  output logic    wr_hit_o,
  output logic    fill_we_o,
  output logic    fill_done_o,
  output logic    wr_last_o
);
  state_e  state_q;
  beat_t   beat_q;
  offset_t word_q;
  logic    mem_read_q, mem_write_q, miss_flag_q, wr_hit_q;
  logic    beat_last;

  assign beat_last = (beat_q == beat_t'(MEM_LAT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      word_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      miss_flag_q <= 1'b0;
      wr_hit_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i && we_i) begin
            state_q     <= WRITE;
            beat_q      <= '0;
            mem_write_q <= 1'b1;
            wr_hit_q    <= hit_i;
          end else if (req_i && !hit_i) begin
            state_q     <= FILL;
            beat_q      <= '0;
            word_q      <= '0;
            mem_read_q  <= 1'b1;
            miss_flag_q <= 1'b1;
          end else if (req_i) begin
            miss_flag_q <= 1'b0;
          end
        end
        FILL: begin
          if (beat_last) begin
            beat_q <= '0;
            if (word_q == offset_t'(LINE_WORDS - 1)) begin
              state_q    <= IDLE;
              mem_read_q <= 1'b0;
            end else begin
              word_q <= word_q + offset_t'(1);
            end
          end else begin
            beat_q <= beat_q + beat_t'(1);
          end
        end
        WRITE: begin
          if (beat_last) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            mem_write_q <= 1'b0;
            miss_flag_q <= 1'b0;
          end else begin
            beat_q <= beat_q + beat_t'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state_o     = state_q;
  assign word_o      = word_q;
  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;
  assign miss_flag_o = miss_flag_q;
  assign wr_hit_o    = wr_hit_q;
  // Memory data is sampled on the edge closing each beat.
  assign fill_we_o   = (state_q == FILL) && beat_last;
  assign fill_done_o = fill_we_o && (word_q == offset_t'(LINE_WORDS - 1));
  assign wr_last_o   = (state_q == WRITE) && beat_last;
endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache: same-cycle read hits,
// word-by-word line fill on read miss, MEM_LAT-cycle write-through on every store.
module dcache_wt
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  dcache_wt_if.slave  bus
);
  logic [NUM_LINES-1:0] valid_q;
  tag_t                 tag_q  [NUM_LINES];
  word_t                data_q [NUM_LINES][LINE_WORDS];
  word_t                hit_count_q, access_count_q;

  state_e  state;
  offset_t fill_word;
  logic    mem_read, mem_write, miss_flag, wr_hit, fill_we, fill_done, wr_last;
  tag_t    req_tag;
  index_t  req_index;
  offset_t req_offset;
  logic    hit, rd_hit, rd_miss, ready;

  assign req_tag    = addr_tag(bus.cpu_addr);
  assign req_index  = addr_index(bus.cpu_addr);
  assign req_offset = addr_offset(bus.cpu_addr);
  assign hit        = valid_q[req_index] && (tag_q[req_index] == req_tag);
  assign rd_hit     = (state == IDLE) && bus.cpu_req && !bus.cpu_we && hit;
  assign rd_miss    = (state == IDLE) && bus.cpu_req && !bus.cpu_we && !hit;
  assign ready      = rd_hit || wr_last;

  dcache_ctrl u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .req_i       (bus.cpu_req),
    .we_i        (bus.cpu_we),
    .hit_i       (hit),
    .state_o     (state),
    .word_o      (fill_word),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .miss_flag_o (miss_flag),
    .wr_hit_o    (wr_hit),
    .fill_we_o   (fill_we),
    .fill_done_o (fill_done),
    .wr_last_o   (wr_last)
  );

  // The line is invalidated at miss start so an abandoned fill never looks resident.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (rd_miss) begin
      valid_q[req_index] <= 1'b0;
    end else if (fill_done) begin
      valid_q[req_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we)           data_q[req_index][fill_word]  <= bus.mem_rdata;
    if (wr_last && wr_hit) data_q[req_index][req_offset] <= bus.cpu_wdata;
    if (fill_done)         tag_q[req_index]              <= req_tag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_q    <= '0;
      access_count_q <= '0;
    end else if (bus.cpu_req && ready) begin
      access_count_q <= access_count_q + word_t'(1);
      if ((!bus.cpu_we && !miss_flag) || (bus.cpu_we && wr_hit))
        hit_count_q <= hit_count_q + word_t'(1);
    end
  end

  assign bus.cpu_ready    = ready;
  assign bus.cpu_rdata    = rd_hit ? data_q[req_index][req_offset] : '0;
  assign bus.mem_read     = mem_read;
  assign bus.mem_write    = mem_write;
  assign bus.mem_addr     = (state == FILL)  ? {req_tag, req_index, fill_word} :
                            (state == WRITE) ? bus.cpu_addr : '0;
  assign bus.mem_wdata    = mem_write ? bus.cpu_wdata : '0;
  assign bus.hit_count    = hit_count_q;
  assign bus.access_count = access_count_q;
endmodule

// File: tb/tb_dcache_wt.sv
// Directed plus random accesses to dcache_wt, checked against a line-residency and memory model.
module tb_dcache_wt;
  import cache_pkg::*;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  dcache_wt_if bus ();

  dcache_wt dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic word_t init_val(input word_t a);
    if (a >= 16'h0020 && a <= 16'h0023) return 16'h1111 * (a - 16'h001F);
    return (a * 16'h9E37) ^ 16'h1234;
  endfunction

  // Backing memory seen by the cache, loaded on the first clock edge while reset is held.
  logic [15:0] mem [0:65535];
  bit          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_val(16'(i));
      mem_init <= 1'b1;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr] : 16'h0000;

  // Reference model: expected memory image, per-line residency, counters.
  word_t ref_mem [0:65535];
  bit    m_valid [NUM_LINES];
  int    m_tag   [NUM_LINES];
  int    m_hit, m_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_LINES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
    end
    m_hit = 0;
    m_acc = 0;
  endtask

  // Called just after a rising edge; returns just after the completing edge.
  task automatic do_access(input logic we, input word_t addr, input word_t wd, input string tag);
    int    line, tg, exp_lat, c;
    bit    hit, done, exp_rs, exp_ws;
    word_t exp_rd;
    line    = (int'(addr) / LINE_WORDS) % NUM_LINES;
    tg      = int'(addr) / (LINE_WORDS * NUM_LINES);
    hit     = m_valid[line] && (m_tag[line] == tg);
    exp_lat = we ? MEM_LAT : (hit ? 0 : 1 + LINE_WORDS * MEM_LAT);
    exp_rd  = ref_mem[addr];
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    c    = 0;
    done = 1'b0;
    while (!done && c <= 40) begin
      @(negedge clk);
      exp_rs = !we && !hit && c >= 1 && c <= LINE_WORDS * MEM_LAT;
      exp_ws = we && c >= 1 && c <= MEM_LAT;
      chk({tag, "_mem_read"},  bus.mem_read,  exp_rs);
      chk({tag, "_mem_write"}, bus.mem_write, exp_ws);
      if (exp_rs)
        chk({tag, "_fill_addr"}, bus.mem_addr,
            {addr[15:2], 2'((c - 1) / MEM_LAT)});
      if (exp_ws) begin
        chk({tag, "_wr_addr"},  bus.mem_addr,  addr);
        chk({tag, "_wr_wdata"}, bus.mem_wdata, wd);
      end
      if (bus.cpu_ready) begin
        done = 1'b1;
        chk({tag, "_latency"}, c, exp_lat);
        if (!we) chk({tag, "_rdata"}, bus.cpu_rdata, exp_rd);
      end
      @(posedge clk);
      #1;
      if (!done) c++;
    end
    chk({tag, "_completed"}, done, 1'b1);
    m_acc++;
    if (hit) m_hit++;
    if (we) begin
      ref_mem[addr] = wd;
    end else begin
      m_valid[line] = 1'b1;
      m_tag[line]   = tg;
    end
    chk({tag, "_hit_count"},    bus.hit_count,    16'(m_hit));
    chk({tag, "_access_count"}, bus.access_count, 16'(m_acc));
    bus.cpu_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(16'(i));
    model_reset();
    reset         = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    chk("rst_ready",     bus.cpu_ready,    1'b0);
    chk("rst_rdata",     bus.cpu_rdata,    16'h0000);
    chk("rst_mem_read",  bus.mem_read,     1'b0);
    chk("rst_mem_write", bus.mem_write,    1'b0);
    chk("rst_hits",      bus.hit_count,    16'h0000);
    chk("rst_accesses",  bus.access_count, 16'h0000);
    @(posedge clk);
    #1;

    do_access(1'b0, 16'h0021, '0, "cold_rd21");
    do_access(1'b0, 16'h0023, '0, "hit_rd23");
    chk("cold_rd23_value", bus.hit_count, 16'd1);

    do_access(1'b0, 16'h0031, '0, "conflict_rd31");
    do_access(1'b0, 16'h0021, '0, "conflict_rd21");

    do_access(1'b1, 16'h0022, 16'hBEEF, "wrhit_22");
    do_access(1'b0, 16'h0022, '0, "wrhit_rd22");

    do_access(1'b1, 16'h0040, 16'h5A5A, "wrmiss_40");
    do_access(1'b0, 16'h0020, '0, "wrmiss_keep_rd20");
    do_access(1'b0, 16'h0040, '0, "wrmiss_rd40");

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_mem_read",  bus.mem_read,  1'b0);
      chk("idle_mem_write", bus.mem_write, 1'b0);
      chk("idle_ready",     bus.cpu_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    chk("idle_access_count", bus.access_count, 16'(m_acc));

    do_access(1'b0, 16'h0020, '0, "b2b_fill20");
    do_access(1'b0, 16'h0020, '0, "b2b_hit20");
    do_access(1'b0, 16'h0021, '0, "b2b_hit21");

    // Evict 0x20, then abort its refill with a reset in the fourth cycle.
    do_access(1'b0, 16'h0030, '0, "evict_rd30");
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h0020;
    repeat (3) @(posedge clk);
    #1;
    chk("midfill_mem_read_before", bus.mem_read, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    bus.cpu_req = 1'b0;
    model_reset();
    @(negedge clk);
    chk("midfill_mem_read_after", bus.mem_read,     1'b0);
    chk("midfill_ready_after",    bus.cpu_ready,    1'b0);
    chk("midfill_hits_after",     bus.hit_count,    16'h0000);
    chk("midfill_accesses_after", bus.access_count, 16'h0000);
    @(posedge clk);
    #1;
    do_access(1'b0, 16'h0020, '0, "postrst_rd20");

    for (int n = 0; n < 200; n++) begin
      logic  we;
      word_t addr, wd;
      we   = ($urandom_range(0, 2) == 0);
      addr = 16'($urandom_range(0, 127));
      wd   = 16'($urandom);
      do_access(we, addr, wd, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
